// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR generator: mode encodings, reference tap masks
// for common widths, and the XOR-reduce helper used by the Fibonacci feedback.
package lfsr_pkg;

    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_GAL = 1'b1;

    // Each width's Fibonacci and Galois masks describe the same primitive polynomial,
    // except width 8, which keeps the two historical board defaults.
    localparam logic [3:0]  FTAPS_4  = 4'hC;
    localparam logic [3:0]  GTAPS_4  = 4'h9;
    localparam logic [7:0]  FTAPS_8  = 8'hB8;
    localparam logic [7:0]  GTAPS_8  = 8'h1D;
    localparam logic [15:0] FTAPS_16 = 16'hB400;
    localparam logic [15:0] GTAPS_16 = 16'h6801;
    localparam logic [21:0] FTAPS_22 = 22'h300000;
    localparam logic [21:0] GTAPS_22 = 22'h200001;
    localparam logic [31:0] FTAPS_32 = 32'h80200003;
    localparam logic [31:0] GTAPS_32 = 32'h00400007;

    function automatic logic xor_reduce(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/lfsr_prescaler.sv
// Free-running enable-gated prescaler; its carry (all-ones while enabled) is the
// step strobe for the LFSR. CLR restarts the count from zero.
module lfsr_prescaler #(
    parameter int DIV_WIDTH = 22
) (
    input  logic CLK,
    input  logic RESET,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);

    logic [DIV_WIDTH-1:0] cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (CLR) begin
            cnt <= '0;
        end else if (EN) begin
            cnt <= cnt + DIV_WIDTH'(1);
        end
    end

    assign TICK = EN && (cnt == '1);

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, zero-lockup recovery and a
// prescaled step strobe. Optional period measurement under LFSR_PERIOD_CHK_EN.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] FTAPS     = 8'hB8,
    parameter logic [WIDTH-1:0] GTAPS     = 8'h1D,
    parameter logic [WIDTH-1:0] SEED      = 8'h01,
    parameter int               DIV_WIDTH = 22
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             MODE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] SEED_IN,
    output logic [WIDTH-1:0] Q,
    output logic             STEP,
    output logic             LOCKUP,
    output logic [WIDTH-1:0] PERIOD,
    output logic             PERIOD_VALID
);

    logic             tick;
    logic [WIDTH-1:0] shift_val;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] load_val;
    logic             zero_state;

    lfsr_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (EN),
        .CLR   (LOAD),
        .TICK  (tick)
    );

    always_comb begin
        shift_val = '0;
        if (MODE == MODE_GAL) begin
            shift_val = {Q[WIDTH-2:0], 1'b0} ^ (Q[WIDTH-1] ? GTAPS : '0);
        end else begin
            shift_val = {Q[WIDTH-2:0], xor_reduce(32'(Q & FTAPS))};
        end
    end

    // A zero state can never advance, so it is replaced by SEED on the tick.
    assign zero_state = (Q == '0);
    assign next_q     = zero_state ? SEED : shift_val;
    assign load_val   = (SEED_IN == '0) ? SEED : SEED_IN;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Q      <= SEED;
            STEP   <= 1'b0;
            LOCKUP <= 1'b0;
        end else begin
            STEP   <= 1'b0;
            LOCKUP <= 1'b0;
            if (LOAD) begin
                Q      <= load_val;
                LOCKUP <= (SEED_IN == '0);
            end else if (tick) begin
                Q      <= next_q;
                STEP   <= !zero_state;
                LOCKUP <= zero_state;
            end
        end
    end

`ifdef LFSR_PERIOD_CHK_EN
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] step_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            start_val    <= SEED;
            step_cnt     <= '0;
            PERIOD       <= '0;
            PERIOD_VALID <= 1'b0;
        end else if (LOAD) begin
            start_val    <= load_val;
            step_cnt     <= '0;
            PERIOD_VALID <= 1'b0;
        end else if (tick) begin
            if (next_q == start_val) begin
                PERIOD       <= step_cnt + WIDTH'(1);
                PERIOD_VALID <= 1'b1;
                step_cnt     <= '0;
            end else begin
                step_cnt <= step_cnt + WIDTH'(1);
            end
        end
    end
`else
    assign PERIOD       = '0;
    assign PERIOD_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Randomised scoreboard bench for lfsr_gen (8-bit defaults, DIV_WIDTH=2) with
// directed sequence, lockup, enable-hold, async-reset and period checks.
module tb_lfsr_gen;

    localparam int W      = 8;
    localparam int DIV    = 2;
    localparam int PS_MAX = (1 << DIV) - 1;
    localparam int SEED_V = 'h01;

    logic         clk = 1'b0;
    logic         RESET;
    logic         EN;
    logic         MODE;
    logic         LOAD;
    logic [W-1:0] SEED_IN;
    logic [W-1:0] Q;
    logic         STEP;
    logic         LOCKUP;
    logic [W-1:0] PERIOD;
    logic         PERIOD_VALID;

    lfsr_gen #(.DIV_WIDTH(DIV)) dut (
        .CLK          (clk),
        .RESET        (RESET),
        .EN           (EN),
        .MODE         (MODE),
        .LOAD         (LOAD),
        .SEED_IN      (SEED_IN),
        .Q            (Q),
        .STEP         (STEP),
        .LOCKUP       (LOCKUP),
        .PERIOD       (PERIOD),
        .PERIOD_VALID (PERIOD_VALID)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [18:0] exp_q[$];
    logic [7:0]  seen_q[$];
    logic [18:0] exp_v;
    logic [18:0] act_v;

    // Reference model state (plain integers)
    int m_q, m_cnt, m_step, m_lock, m_start, m_pcnt, m_period, m_pvalid;
    int ftaps = 'hB8;
    int gtaps = 'h1D;

    logic [7:0] fib_ref[5] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    logic [7:0] gal_ref[8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q = SEED_V; m_cnt = 0; m_step = 0; m_lock = 0;
        m_start = SEED_V; m_pcnt = 0; m_period = 0; m_pvalid = 0;
    endtask

    task automatic model_edge(input logic en, input logic mode, input logic load, input int seed);
        int tick, fb, nq;
        tick = (en && m_cnt == PS_MAX) ? 1 : 0;
        m_step = 0;
        m_lock = 0;
        if (load) begin
            m_cnt = 0;
            if (seed == 0) begin
                m_q = SEED_V;
                m_lock = 1;
            end else begin
                m_q = seed;
            end
            m_start = m_q;
            m_pcnt = 0;
            m_pvalid = 0;
        end else begin
            if (en) m_cnt = (m_cnt + 1) % (PS_MAX + 1);
            if (tick != 0) begin
                if (m_q == 0) begin
                    nq = SEED_V;
                    m_lock = 1;
                end else if (mode == 1'b0) begin
                    fb = 0;
                    for (int i = 0; i < W; i++) fb ^= ((ftaps >> i) & 1) & ((m_q >> i) & 1);
                    nq = (m_q * 2 + fb) % 256;
                    m_step = 1;
                end else begin
                    nq = (m_q * 2) % 256;
                    if (m_q >= 128) nq = nq ^ gtaps;
                    m_step = 1;
                end
                if (nq == m_start) begin
                    m_period = (m_pcnt + 1) % 256;
                    m_pvalid = 1;
                    m_pcnt = 0;
                end else begin
                    m_pcnt = (m_pcnt + 1) % 256;
                end
                m_q = nq;
            end
        end
    endtask

    function automatic logic [18:0] model_pack();
`ifdef LFSR_PERIOD_CHK_EN
        return {8'(m_q), 1'(m_step), 1'(m_lock), 8'(m_period), 1'(m_pvalid)};
`else
        return {8'(m_q), 1'(m_step), 1'(m_lock), 8'h00, 1'b0};
`endif
    endfunction

    // Called at posedge+2: drive inputs for the coming edge and queue its result.
    task automatic drive(input logic en, input logic mode, input logic load, input logic [7:0] seed);
        EN = en; MODE = mode; LOAD = load; SEED_IN = seed;
        model_edge(en, mode, load, int'(seed));
        exp_q.push_back(model_pack());
        @(posedge clk);
        #2;
    endtask

    // Monitor: one result per clock edge, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (!RESET && exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {Q, STEP, LOCKUP, PERIOD, PERIOD_VALID};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL scoreboard @%0t: got q=%h step=%b lock=%b per=%h pv=%b expected q=%h step=%b lock=%b per=%h pv=%b",
                         $time, act_v[18:11], act_v[10], act_v[9], act_v[8:1], act_v[0],
                         exp_v[18:11], exp_v[10], exp_v[9], exp_v[8:1], exp_v[0]);
            end
            if (STEP === 1'b1) seen_q.push_back(Q);
        end
    end

    initial begin
        int n;
        RESET = 1'b1; EN = 1'b0; MODE = 1'b0; LOAD = 1'b0; SEED_IN = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_q", int'(Q), SEED_V);
        check("reset_step", int'(STEP), 0);
        check("reset_lockup", int'(LOCKUP), 0);
        check("reset_period", int'(PERIOD), 0);
        check("reset_pvalid", int'(PERIOD_VALID), 0);
        RESET = 1'b0;
        model_reset();

        // Fibonacci from reset seed
        seen_q.delete();
        repeat (20) drive(1'b1, 1'b0, 1'b0, 8'h00);
        check("fib_count", seen_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < seen_q.size()) check($sformatf("fib_seq[%0d]", i), int'(seen_q[i]), int'(fib_ref[i]));

        // Galois from seed 01
        drive(1'b1, 1'b1, 1'b1, 8'h01);
        seen_q.delete();
        repeat (32) drive(1'b1, 1'b1, 1'b0, 8'h00);
        check("gal_count", seen_q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < seen_q.size()) check($sformatf("gal_seq[%0d]", i), int'(seen_q[i]), int'(gal_ref[i]));

        // Zero load -> SEED with lockup pulse, then a normal load
        drive(1'b1, 1'b0, 1'b1, 8'h00);
        check("zero_load_q", int'(Q), SEED_V);
        check("zero_load_lockup", int'(LOCKUP), 1);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        check("lockup_one_cycle", int'(LOCKUP), 0);
        drive(1'b1, 1'b0, 1'b1, 8'h5A);
        check("load_5a_q", int'(Q), 'h5A);
        check("load_no_step", int'(STEP), 0);

        // Enable hold mid-count delays the advance by exactly the hold length
        seen_q.delete();
        repeat (2) drive(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (10) drive(1'b0, 1'b0, 1'b0, 8'h00);
        n = 0;
        while (seen_q.size() == 0 && n < 20) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00);
            n++;
        end
        check("en_hold_delay", n + 12, 14);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
        end

        // Asynchronous reset between edges
        repeat (6) drive(1'b1, 1'b0, 1'b0, 8'h00);
        #1;
        RESET = 1'b1;
        exp_q.delete();
        #1;
        check("async_reset_q", int'(Q), SEED_V);
        check("async_reset_step", int'(STEP), 0);
        check("async_reset_lockup", int'(LOCKUP), 0);
        @(posedge clk);
        #2;
        RESET = 1'b0;
        model_reset();

        // Full-period runs in both modes
        drive(1'b1, 1'b0, 1'b1, 8'h01);
        repeat (1030) drive(1'b1, 1'b0, 1'b0, 8'h00);
`ifdef LFSR_PERIOD_CHK_EN
        check("fib_period", int'(PERIOD), 255);
        check("fib_pvalid", int'(PERIOD_VALID), 1);
`else
        check("fib_period_tied", int'(PERIOD), 0);
        check("fib_pvalid_tied", int'(PERIOD_VALID), 0);
`endif
        drive(1'b1, 1'b1, 1'b1, 8'h01);
        check("load_clears_pvalid", int'(PERIOD_VALID), 0);
        repeat (1030) drive(1'b1, 1'b1, 1'b0, 8'h00);
`ifdef LFSR_PERIOD_CHK_EN
        check("gal_period", int'(PERIOD), 255);
        check("gal_pvalid", int'(PERIOD_VALID), 1);
`else
        check("gal_period_tied", int'(PERIOD), 0);
        check("gal_pvalid_tied", int'(PERIOD_VALID), 0);
`endif
        drive(1'b1, 1'b0, 1'b1, 8'h5A);
        check("load_clears_pvalid_2", int'(PERIOD_VALID), 0);
        repeat (4) drive(1'b1, 1'b0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised linear-feedback shift register generator for board-level pattern and PRBS output. Successor to the fixed 8-bit LED-pattern LFSR. Adds configurable width and taps, runtime Fibonacci/Galois mode, seed load, zero-lockup protection and an enable-gated prescaler. Sits between the board clock and pattern or LED outputs; the prescaler's carry acts as the step strobe.

Parameters:
WIDTH, 8, LFSR state width (2..32)
FTAPS, 8'hB8, Fibonacci tap mask: bit i set means state[i] enters the XOR feedback (default is x^8+x^6+x^5+x^4+1)
GTAPS, 8'h1D, Galois toggle mask, XORed in when the shifted-out MSB is 1 (default is x^8+x^4+x^3+x^2+1)
SEED, 8'h01, reset and lockup-recovery state; must be nonzero
DIV_WIDTH, 22, prescaler width; one step every 2^DIV_WIDTH enabled cycles (1..32)

Ports:
CLK  in  1  clock; all state updates on its rising edge
RESET  in  1  asynchronous, active-high reset
EN  in  1  prescaler enable; when low, the prescaler and state hold
MODE  in  1  0 = Fibonacci, 1 = Galois; sampled at each step
LOAD  in  1  synchronous seed load
SEED_IN  in  WIDTH  value loaded when LOAD=1
Q  out  WIDTH  current LFSR state
STEP  out  1  registered; high for one cycle after each state advance
LOCKUP  out  1  registered; high for one cycle after a zero load is replaced by SEED
PERIOD  out  WIDTH  measured sequence period (optional feature)
PERIOD_VALID  out  1  PERIOD holds a valid value (optional feature)

Behaviour:
- Reset values: Q=SEED, prescaler=0, STEP=0, LOCKUP=0, PERIOD=0, PERIOD_VALID=0. Reset acts immediately, including mid-sequence.
- Prescaler: counts up by 1 each cycle while EN=1 and wraps at all-ones. tick = EN && (cnt == all-ones). The first advance occurs on the 2^DIV_WIDTH-th enabled edge after reset.
- Fibonacci step: fb = XOR-reduce(Q & FTAPS); next Q = {Q[WIDTH-2:0], fb}.
- Galois step: next Q = {Q[WIDTH-2:0], 0} XOR (Q[WIDTH-1] ? GTAPS : 0).
- Priority on each edge: RESET > LOAD > tick > hold.
- LOAD: Q <= SEED_IN and prescaler <= 0. If SEED_IN == 0, Q <= SEED instead and LOCKUP pulses. LOAD suppresses any simultaneous tick (STEP=0 that cycle).
- Zero-state guard: if Q is ever 0 at a tick, load SEED instead of stepping and pulse LOCKUP. This is unreachable with legal taps and exists for robustness.
- STEP is 1 in the cycle after the state advances. It is not asserted for loads.
- A MODE change takes effect at the next tick. No flush or reload is performed.
- EN low freezes both the prescaler and Q. EN high resumes with no lost count.

Optional Feature:
LFSR_PERIOD_CHK_EN defined:
- A WIDTH-bit step counter clears on reset and on LOAD, and increments on each tick.
- On the tick where next Q equals the start value (the value latched at reset or LOAD), PERIOD <= counter+1 and PERIOD_VALID <= 1. The counter then restarts.
- LOAD clears PERIOD_VALID.

LFSR_PERIOD_CHK_EN undefined:
- PERIOD and PERIOD_VALID are tied to 0.
- No counter logic is generated.

Decomposition:
- Package lfsr_pkg holds:
  - mode constants MODE_FIB=0 and MODE_GAL=1
  - default tap constants for widths 4, 8, 16, 22 and 32, in Fibonacci and Galois forms
  - the XOR-reduce helper function
- Sub-module lfsr_prescaler(DIV_WIDTH): CLK, RESET, EN, CLR in; TICK out. It is a counter with carry-as-tick. The top block instantiates it once.

Test Plan:
- Reset, DIV_WIDTH=1, EN=1, MODE=0 -> Q sequence 01,02,04,08,11,23. STEP pulses every 2 cycles.
- MODE=1, seed 01, DIV_WIDTH=1 -> Q sequence 02,04,08,10,20,40,80,1D.
- LOAD with SEED_IN=0x00 -> Q=0x01 next cycle and LOCKUP pulses once. LOAD with 0x5A -> Q=0x5A and the prescaler restarts from 0.
- EN toggled low for 10 cycles mid-count -> Q and the prescaler hold. The advance is delayed exactly 10 cycles.
- RESET asserted asynchronously between clock edges mid-sequence -> Q=SEED immediately. STEP and LOCKUP are 0.
- With LFSR_PERIOD_CHK_EN and DIV_WIDTH=1, run both modes from 01 -> PERIOD=255 and PERIOD_VALID=1 after 255 steps. LOAD clears PERIOD_VALID.
